// File: rtl/vchip8_keypad_scanner.sv
// 4x4 CHIP-8 keypad scanner: column drive, row sync/debounce, PIO status byte.
// Optional KEYSCAN_IRQ_EN adds a one-cycle irq pulse per accepted new key press.
module vchip8_keypad_scanner #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  input  logic        ack,
  output logic [15:0] key_state,
  output logic [7:0]  periph_byte
`ifdef KEYSCAN_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_DRIVE,
    ST_SAMPLE,
    ST_COMPARE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_col;
  logic [SW-1:0] r_settle;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [15:0]   r_raw;
  logic [15:0]   r_prev_raw;
  logic [3:0]    r_stable;
  logic [3:0]    r_col_n;
  logic [15:0]   r_key_state;
  logic          r_event;
  logic [7:0]    r_periph;
`ifdef KEYSCAN_IRQ_EN
  logic          r_irq;
`endif

  logic          w_raw_same;
  logic          w_accept;
  logic          w_new_press;
  logic [15:0]   w_key_next;
  logic          w_event_next;
  logic [3:0]    w_low_idx;

  // Accept only on the scan where the stable count first reaches the threshold.
  assign w_raw_same   = (r_raw == r_prev_raw);
  assign w_accept     = (r_state == ST_COMPARE) && w_raw_same &&
                        (r_stable == 4'(DEBOUNCE_SCANS - 1)) &&
                        (r_raw != r_key_state);
  assign w_new_press  = w_accept && (|(r_raw & ~r_key_state));
  assign w_key_next   = w_accept ? r_raw : r_key_state;
  assign w_event_next = w_new_press | (r_event & ~ack);

  always_comb begin
    w_low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_key_next[i]) w_low_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_DRIVE;
      r_col       <= 2'd0;
      r_settle    <= '0;
      r_sync1     <= 4'b1111;
      r_sync2     <= 4'b1111;
      r_raw       <= 16'h0000;
      r_prev_raw  <= 16'h0000;
      r_stable    <= 4'd0;
      r_col_n     <= 4'b1111;
      r_key_state <= 16'h0000;
      r_event     <= 1'b0;
      r_periph    <= 8'h00;
`ifdef KEYSCAN_IRQ_EN
      r_irq       <= 1'b0;
`endif
    end else begin
      r_sync1     <= row_n;
      r_sync2     <= r_sync1;
      r_key_state <= w_key_next;
      r_event     <= w_event_next;
      r_periph    <= {|w_key_next, w_event_next, 2'b00, w_low_idx};
`ifdef KEYSCAN_IRQ_EN
      r_irq       <= w_new_press;
`endif
      case (r_state)
        ST_DRIVE: begin
          r_col_n <= ~(4'b0001 << r_col);
          if (r_settle == SW'(SETTLE_CYCLES - 1)) begin
            r_settle <= '0;
            r_state  <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        ST_SAMPLE: begin
          r_raw[{r_col, 2'b00} +: 4] <= ~r_sync2;
          if (r_col == 2'd3) begin
            r_state <= ST_COMPARE;
          end else begin
            r_col   <= r_col + 2'd1;
            r_state <= ST_DRIVE;
          end
        end
        ST_COMPARE: begin
          r_col_n <= 4'b1111;
          r_col   <= 2'd0;
          r_state <= ST_DRIVE;
          if (!w_raw_same) begin
            r_prev_raw <= r_raw;
            r_stable   <= 4'd0;
          end else if (r_stable < 4'(DEBOUNCE_SCANS)) begin
            r_stable <= r_stable + 4'd1;
          end
        end
        default: r_state <= ST_DRIVE;
      endcase
    end
  end

  assign col_n       = r_col_n;
  assign key_state   = r_key_state;
  assign periph_byte = r_periph;
`ifdef KEYSCAN_IRQ_EN
  assign irq         = r_irq;
`endif

endmodule
